// File: rtl/dma_block_sequencer_pkg.sv
// dma_block_sequencer_pkg: shared types, widths and helpers for the SD DMA block sequencer.
package dma_seq_pkg;
  localparam int BLK_SIZE_W = 12;
  localparam int BLK_CNT_W = 16;
  localparam int WORD_IDX_W = 10;
  localparam int WPB_W = 11;
  localparam int WORD_BYTES = 4;
  localparam logic [1:0] CMD_TYPE_ABORT = 2'b11;
  typedef enum logic [2:0] {IDLE, WAIT_BUF, XFER, BLOCK_END, GAP, DONE} state_e;
  function automatic logic [WPB_W-1:0] words_per_block(input logic [BLK_SIZE_W-1:0] size);
    logic [BLK_SIZE_W:0] s;
    s = {1'b0, size} + (BLK_SIZE_W+1)'(WORD_BYTES - 1);
    return s[BLK_SIZE_W:2];
  endfunction
endpackage

// File: rtl/dma_block_sequencer_if.sv
// dma_block_sequencer_if: register fields, buffer flags, DMA handshake and event outputs.
interface dma_block_sequencer_if;
  import dma_seq_pkg::*;
  logic Start;
  logic [BLK_SIZE_W-1:0] Block_Size;
  logic [BLK_CNT_W-1:0] Block_Count;
  logic Multi_Block;
  logic Read_Direction;
  logic Block_Count_Enable;
  logic DMA_Enable;
  logic Buffer_Read_Enable;
  logic Buffer_Write_Enable;
  logic Stop_At_Gap;
  logic Continue_Request;
  logic [1:0] Command_Type;
  logic Cmd_Issue;
  logic Dma_Ack;
  logic Dma_Req;
  logic Dma_To_Memory;
  logic Busy;
  logic Block_Done;
  logic Block_Gap_Event;
  logic Transfer_Complete;
  logic [BLK_CNT_W-1:0] Blocks_Remaining;
  logic [WORD_IDX_W-1:0] Word_Index;
  modport master (
    output Start, Block_Size, Block_Count, Multi_Block, Read_Direction, Block_Count_Enable,
           DMA_Enable, Buffer_Read_Enable, Buffer_Write_Enable, Stop_At_Gap, Continue_Request,
           Command_Type, Cmd_Issue, Dma_Ack,
    input  Dma_Req, Dma_To_Memory, Busy, Block_Done, Block_Gap_Event, Transfer_Complete,
           Blocks_Remaining, Word_Index
  );
  modport slave (
    input  Start, Block_Size, Block_Count, Multi_Block, Read_Direction, Block_Count_Enable,
           DMA_Enable, Buffer_Read_Enable, Buffer_Write_Enable, Stop_At_Gap, Continue_Request,
           Command_Type, Cmd_Issue, Dma_Ack,
    output Dma_Req, Dma_To_Memory, Busy, Block_Done, Block_Gap_Event, Transfer_Complete,
           Blocks_Remaining, Word_Index
  );
endinterface

// File: rtl/dma_block_sequencer_word_counter.sv
// dma_word_counter: word index within a block with terminal flag against latched words_per_block.
module dma_word_counter
  import dma_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  clr_i,
  input  logic                  inc_i,
  input  logic [WPB_W-1:0]      wpb_i,
  output logic [WORD_IDX_W-1:0] idx_o,
  output logic                  last_o
);
  logic [WPB_W-1:0] wpb_q, wpb_d;
  logic [WORD_IDX_W-1:0] idx_q, idx_d;
  always_comb begin
    wpb_d = load_i ? wpb_i : wpb_q;
    idx_d = clr_i ? '0 : inc_i ? idx_q + 1'b1 : idx_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wpb_q <= '0;
      idx_q <= '0;
    end else begin
      wpb_q <= wpb_d;
      idx_q <= idx_d;
    end
  end
  assign idx_o = idx_q;
  assign last_o = {1'b0, idx_q} == wpb_q - 1'b1;
endmodule

// File: rtl/dma_block_sequencer.sv
// dma_block_sequencer: block-by-block SD host DMA sequencing with gap stop and deferred abort.
module dma_block_sequencer
  import dma_seq_pkg::*;
(
  input logic CLK,
  input logic RESET,
  dma_block_sequencer_if.slave bus
);
  state_e state_q, state_d;
  logic [BLK_CNT_W-1:0] rem_q, rem_d;
  logic counted_q, counted_d, dir_q, dir_d, pend_q, pend_d, gap_q, gap_d;
  logic abort, start_ok, empty, buf_ok, ack, last_word, last_blk;
  assign abort = bus.Cmd_Issue && bus.Command_Type == CMD_TYPE_ABORT;
  assign start_ok = state_q == IDLE && bus.Start && bus.DMA_Enable;
  assign empty = bus.Block_Size == '0 ||
                 (bus.Multi_Block && bus.Block_Count_Enable && bus.Block_Count == '0);
  assign buf_ok = dir_q ? bus.Buffer_Read_Enable : bus.Buffer_Write_Enable;
  assign ack = state_q == XFER && bus.Dma_Ack;
  assign last_blk = counted_q && rem_q == 16'd1;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = !start_ok ? IDLE : empty ? DONE : WAIT_BUF;
      WAIT_BUF:  state_d = abort ? DONE : buf_ok ? XFER : WAIT_BUF;
      XFER:      state_d = ack && last_word ? BLOCK_END : XFER;
      BLOCK_END: state_d = last_blk || pend_q || abort ? DONE : bus.Stop_At_Gap ? GAP : WAIT_BUF;
      GAP:       state_d = abort ? DONE : bus.Continue_Request ? WAIT_BUF : GAP;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end
  // Unbounded multi-block keeps the counter parked at 0; counted mode never wraps below 0.
  always_comb begin
    counted_d = start_ok ? !bus.Multi_Block || bus.Block_Count_Enable : counted_q;
    dir_d = start_ok ? bus.Read_Direction : dir_q;
    rem_d = start_ok ? (!bus.Multi_Block ? 16'd1 : bus.Block_Count_Enable ? bus.Block_Count : '0) :
            (state_q == BLOCK_END && counted_q && rem_q != '0) ? rem_q - 1'b1 : rem_q;
    pend_d = state_q == IDLE ? 1'b0 : pend_q || (abort && (state_q == XFER || state_q == BLOCK_END));
    gap_d = state_q == BLOCK_END && state_d == GAP;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      rem_q <= '0;
      counted_q <= 1'b0;
      dir_q <= 1'b0;
      pend_q <= 1'b0;
      gap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      counted_q <= counted_d;
      dir_q <= dir_d;
      pend_q <= pend_d;
      gap_q <= gap_d;
    end
  end
  dma_word_counter u_word_counter (
    .clk    (CLK),
    .rst    (RESET),
    .load_i (start_ok),
    .clr_i  (start_ok || (ack && last_word)),
    .inc_i  (ack),
    .wpb_i  (words_per_block(bus.Block_Size)),
    .idx_o  (bus.Word_Index),
    .last_o (last_word)
  );
  assign bus.Dma_Req = state_q == XFER;
  assign bus.Dma_To_Memory = dir_q;
  assign bus.Busy = state_q != IDLE;
  assign bus.Block_Done = state_q == BLOCK_END;
  assign bus.Block_Gap_Event = gap_q;
  assign bus.Transfer_Complete = state_q == DONE;
  assign bus.Blocks_Remaining = rem_q;
endmodule

// File: tb/tb_dma_block_sequencer.sv
// tb_dma_block_sequencer: scoreboard bench for block/gap/complete events plus DMA word accounting.
module tb_dma_block_sequencer;
  import dma_seq_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0, n_pass = 0, cyc_n = 0, req_cnt = 0, ack_cnt = 0;
  int bd_cyc = 0, tc_cyc = 0, idle_cyc = 0, ack_mode = 0, c0 = 0;
  logic [18:0] sb_q[$];
  dma_block_sequencer_if bus();
  dma_block_sequencer dut (.CLK(clk), .RESET(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask
  function automatic logic [18:0] ev(input logic bd, input logic gap, input logic tc, input logic [15:0] r);
    return {bd, gap, tc, r};
  endfunction
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.Dma_Req) begin
        req_cnt++;
        if (bus.Dma_Ack) ack_cnt++;
      end
      if (bus.Block_Done) bd_cyc = cyc_n;
      if (bus.Transfer_Complete) tc_cyc = cyc_n;
      if (bus.Block_Done || bus.Block_Gap_Event || bus.Transfer_Complete) begin
        if (sb_q.size() == 0)
          chk("sb_unexpected", {13'd0, ev(bus.Block_Done, bus.Block_Gap_Event, bus.Transfer_Complete, bus.Blocks_Remaining)}, 32'd0);
        else
          chk("sb_event", {13'd0, ev(bus.Block_Done, bus.Block_Gap_Event, bus.Transfer_Complete, bus.Blocks_Remaining)}, {13'd0, sb_q.pop_front()});
      end
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    bus.Dma_Ack = ack_mode == 1 ? 1'b1 : ack_mode == 2 ? ~bus.Dma_Ack : 1'b0;
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic start_xfer();
    c0 = cyc_n;
    bus.Start = 1'b1;
    cyc(1);
    bus.Start = 1'b0;
  endtask
  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!bus.Busy) break;
    end
    chk("idle_timeout", bus.Busy, 0);
    idle_cyc = cyc_n;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_word(input logic [9:0] w, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.Dma_Req && bus.Word_Index == w) break;
    end
    chk("word_reached", {bus.Dma_Req, bus.Word_Index}, {1'b1, w});
  endtask
  task automatic cfg(input logic [11:0] sz, input logic [15:0] cnt, input logic mb, input logic rd, input logic bce);
    bus.Block_Size = sz;
    bus.Block_Count = cnt;
    bus.Multi_Block = mb;
    bus.Read_Direction = rd;
    bus.Block_Count_Enable = bce;
    bus.Buffer_Read_Enable = rd;
    bus.Buffer_Write_Enable = !rd;
    req_cnt = 0;
    ack_cnt = 0;
  endtask
  initial begin
    bus.Start = 0; bus.Cmd_Issue = 0; bus.Command_Type = 2'b00; bus.Dma_Ack = 0;
    bus.DMA_Enable = 1; bus.Stop_At_Gap = 0; bus.Continue_Request = 0;
    cfg(12'd0, 16'd0, 0, 0, 0);
    cyc(3);
    @(negedge clk);
    chk("rst_flags", {bus.Dma_Req, bus.Dma_To_Memory, bus.Busy, bus.Block_Done, bus.Block_Gap_Event, bus.Transfer_Complete}, 0);
    chk("rst_rem", bus.Blocks_Remaining, 0);
    chk("rst_idx", bus.Word_Index, 0);
    @(posedge clk); #1;
    rst = 0;
    ack_mode = 1;
    cyc(2);
    // single 512-byte read block
    cfg(12'd512, 16'd0, 0, 1, 0);
    sb_q.push_back(ev(1, 0, 0, 16'd1));
    sb_q.push_back(ev(0, 0, 1, 16'd0));
    start_xfer();
    chk("lat_wait_buf", {bus.Busy, bus.Dma_Req}, 2'b10);
    chk("to_mem_rd", bus.Dma_To_Memory, 1);
    cyc(1);
    chk("lat_first_req", bus.Dma_Req, 1);
    wait_idle(300);
    chk("single_req", req_cnt, 128);
    chk("single_ack", ack_cnt, 128);
    chk("tc_after_bd", tc_cyc - bd_cyc, 1);
    chk("busy_after_bd", idle_cyc - bd_cyc, 2);
    // counted 3 x 8-byte write blocks, alternating ack, Start while busy ignored
    cfg(12'd8, 16'd3, 1, 0, 1);
    ack_mode = 2;
    sb_q.push_back(ev(1, 0, 0, 16'd3));
    sb_q.push_back(ev(1, 0, 0, 16'd2));
    sb_q.push_back(ev(1, 0, 0, 16'd1));
    sb_q.push_back(ev(0, 0, 1, 16'd0));
    start_xfer();
    cyc(3);
    chk("to_mem_wr", bus.Dma_To_Memory, 0);
    bus.Block_Size = 12'd64; bus.Block_Count = 16'd9; bus.Read_Direction = 1;
    bus.Start = 1; cyc(1); bus.Start = 0;
    cyc(1);
    chk("busy_start_dir", bus.Dma_To_Memory, 0);
    wait_idle(200);
    chk("multi_ack", ack_cnt, 6);
    chk("multi_rem_end", bus.Blocks_Remaining, 0);
    // gap after block 1 of 4
    ack_mode = 1;
    cfg(12'd8, 16'd4, 1, 0, 1);
    bus.Stop_At_Gap = 1;
    sb_q.push_back(ev(1, 0, 0, 16'd4));
    sb_q.push_back(ev(0, 1, 0, 16'd3));
    start_xfer();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.Block_Gap_Event) break;
    end
    chk("gap_seen", bus.Block_Gap_Event, 1);
    chk("gap_rem", bus.Blocks_Remaining, 3);
    bus.Stop_At_Gap = 0;
    req_cnt = 0;
    ack_cnt = 0;
    repeat (20) @(negedge clk);
    chk("gap_req_low", req_cnt, 0);
    chk("gap_busy", bus.Busy, 1);
    sb_q.push_back(ev(1, 0, 0, 16'd3));
    sb_q.push_back(ev(1, 0, 0, 16'd2));
    sb_q.push_back(ev(1, 0, 0, 16'd1));
    sb_q.push_back(ev(0, 0, 1, 16'd0));
    @(posedge clk); #1;
    bus.Continue_Request = 1; cyc(1); bus.Continue_Request = 0;
    wait_idle(200);
    chk("gap_resume_ack", ack_cnt, 6);
    // abort at word 2 of an unbounded 4-word block stream
    cfg(12'd16, 16'd0, 1, 1, 0);
    sb_q.push_back(ev(1, 0, 0, 16'd0));
    sb_q.push_back(ev(0, 0, 1, 16'd0));
    start_xfer();
    wait_word(10'd2, 50);
    bus.Cmd_Issue = 1; bus.Command_Type = CMD_TYPE_ABORT;
    @(negedge clk);
    bus.Cmd_Issue = 0; bus.Command_Type = 2'b00;
    wait_idle(50);
    chk("abort_ack", ack_cnt, 4);
    req_cnt = 0;
    cyc(10);
    chk("abort_no_req", req_cnt, 0);
    chk("abort_rem", bus.Blocks_Remaining, 0);
    // 5-byte block rounds up to 2 words
    cfg(12'd5, 16'd0, 0, 1, 0);
    sb_q.push_back(ev(1, 0, 0, 16'd1));
    sb_q.push_back(ev(0, 0, 1, 16'd0));
    start_xfer();
    wait_idle(50);
    chk("size5_ack", ack_cnt, 2);
    // counted with Block_Count=0 completes without any request
    cfg(12'd64, 16'd0, 1, 1, 1);
    sb_q.push_back(ev(0, 0, 1, 16'd0));
    start_xfer();
    wait_idle(20);
    chk("empty_req", req_cnt, 0);
    chk("empty_tc_lat", (tc_cyc - c0 == 1) || (tc_cyc - c0 == 2), 1);
    // Start with DMA disabled is ignored
    bus.DMA_Enable = 0;
    start_xfer();
    cyc(3);
    chk("dma_dis_busy", bus.Busy, 0);
    bus.DMA_Enable = 1;
    // reset at word 7, then a fresh block from word 0
    cfg(12'd64, 16'd0, 0, 1, 0);
    start_xfer();
    wait_word(10'd7, 50);
    rst = 1;
    @(posedge clk); #1;
    chk("rst_mid_flags", {bus.Dma_Req, bus.Dma_To_Memory, bus.Busy, bus.Block_Done, bus.Block_Gap_Event, bus.Transfer_Complete}, 0);
    chk("rst_mid_idx", {bus.Blocks_Remaining, bus.Word_Index}, 0);
    rst = 0;
    cyc(1);
    cfg(12'd16, 16'd0, 0, 1, 0);
    sb_q.push_back(ev(1, 0, 0, 16'd1));
    sb_q.push_back(ev(0, 0, 1, 16'd0));
    start_xfer();
    cyc(1);
    chk("fresh_first_word", {bus.Dma_Req, bus.Word_Index}, {1'b1, 10'd0});
    wait_idle(50);
    chk("fresh_ack", ack_cnt, 4);
    chk("sb_drain", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
